// File: rtl/spi_master_cs_ctrl.sv
// spi_master_cs_ctrl
// Transaction sequencer in front of an SPI master byte engine. Takes a byte
// count and a stream of TX bytes from the user side, wraps the whole burst in
// an active-low chip select with programmable setup/hold/inactive gaps, feeds
// the master one byte at a time and forwards received bytes with their index.
module spi_master_cs_ctrl #(
  parameter int MAX_BYTES        = 2,
  parameter int CS_SETUP_CLKS    = 2,
  parameter int CS_HOLD_CLKS     = 2,
  parameter int CS_INACTIVE_CLKS = 4,
  parameter int CNT_W            = $clog2(MAX_BYTES + 1)
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  // user side
  input  logic [CNT_W-1:0] i_TX_Count,
  input  logic [7:0]       i_TX_Byte,
  input  logic             i_TX_DV,
  output logic             o_TX_Ready,
  output logic [CNT_W-1:0] o_RX_Count,
  output logic             o_RX_DV,
  output logic [7:0]       o_RX_Byte,
  // SPI master byte engine side
  output logic [7:0]       o_M_TX_Byte,
  output logic             o_M_TX_DV,
  input  logic             i_M_TX_Ready,
  input  logic             i_M_RX_DV,
  input  logic [7:0]       i_M_RX_Byte,
  // chip select
  output logic             o_SPI_CS_n
);

  localparam int TMR_MAX_SH = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int TMR_MAX    = (TMR_MAX_SH > CS_INACTIVE_CLKS) ? TMR_MAX_SH : CS_INACTIVE_CLKS;
  localparam int TMR_W      = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
  localparam logic [TMR_W-1:0] SETUP_LD    = TMR_W'(CS_SETUP_CLKS);
  localparam logic [TMR_W-1:0] HOLD_LD     = TMR_W'(CS_HOLD_CLKS);
  localparam logic [TMR_W-1:0] INACTIVE_LD = TMR_W'(CS_INACTIVE_CLKS);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_TRANSFER,
    ST_CS_HOLD,
    ST_CS_INACTIVE
  } state_e;

  state_e           state_q,     state_d;
  logic [TMR_W-1:0] timer_q,     timer_d;
  logic             cs_n_q,      cs_n_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       hold_byte_q, hold_byte_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [CNT_W-1:0] tx_sent_q,   tx_sent_d;
  logic [CNT_W-1:0] rx_cnt_q,    rx_cnt_d;
  logic             m_tx_dv_q,   m_tx_dv_d;
  logic [7:0]       m_tx_byte_q, m_tx_byte_d;
  logic             rx_dv_q,     rx_dv_d;
  logic [7:0]       rx_byte_q,   rx_byte_d;
  logic [CNT_W-1:0] rx_count_q,  rx_count_d;

  logic tx_ready;
  logic xfer_go;

  // Next-state, handoff and user-ready decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    timer_d     = timer_q;
    cs_n_d      = cs_n_q;
    hold_full_d = hold_full_q;
    hold_byte_d = hold_byte_q;
    count_d     = count_q;
    tx_sent_d   = tx_sent_q;
    rx_cnt_d    = rx_cnt_q;
    m_tx_dv_d   = 1'b0;
    m_tx_byte_d = m_tx_byte_q;
    rx_dv_d     = 1'b0;
    rx_byte_d   = rx_byte_q;
    rx_count_d  = rx_count_q;
    tx_ready    = 1'b0;

    // The last setup cycle may already launch the first byte, so the master
    // DV lands exactly CS_SETUP_CLKS cycles after CS_n falls.
    xfer_go = (state_q == ST_TRANSFER) ||
              ((state_q == ST_CS_SETUP) && (timer_q == TMR_ONE));

    // Master handoff: one-cycle DV pulse; the m_tx_dv_q guard covers the
    // cycle before the master's ready has had a chance to drop.
    if (xfer_go && hold_full_q && i_M_TX_Ready && !m_tx_dv_q) begin
      m_tx_dv_d   = 1'b1;
      m_tx_byte_d = hold_byte_q;
      hold_full_d = 1'b0;
      tx_sent_d   = tx_sent_q + CNT_ONE;
    end

    unique case (state_q)
      ST_IDLE: begin
        tx_ready = 1'b1;
        if (i_TX_DV) begin
          hold_byte_d = i_TX_Byte;
          hold_full_d = 1'b1;
          count_d     = (i_TX_Count == '0) ? CNT_ONE : i_TX_Count;
          tx_sent_d   = '0;
          rx_cnt_d    = '0;
          rx_count_d  = '0;
          cs_n_d      = 1'b0;
          timer_d     = SETUP_LD;
          state_d     = ST_CS_SETUP;
        end
      end

      ST_CS_SETUP: begin
        timer_d = timer_q - TMR_ONE;
        if (timer_q == TMR_ONE) state_d = ST_TRANSFER;
      end

      ST_TRANSFER: begin
        // An empty holding register means nothing is queued, so the bytes
        // handed over so far are just tx_sent.
        tx_ready = !hold_full_q && (tx_sent_q < count_q);
        if (tx_ready && i_TX_DV) begin
          hold_byte_d = i_TX_Byte;
          hold_full_d = 1'b1;
        end
        if (i_M_RX_DV) begin
          rx_dv_d    = 1'b1;
          rx_byte_d  = i_M_RX_Byte;
          rx_count_d = rx_cnt_q;
          rx_cnt_d   = rx_cnt_q + CNT_ONE;
          if (rx_cnt_d == count_q) begin
            timer_d = HOLD_LD;
            state_d = ST_CS_HOLD;
          end
        end
      end

      ST_CS_HOLD: begin
        timer_d = timer_q - TMR_ONE;
        if (timer_q == TMR_ONE) begin
          cs_n_d  = 1'b1;
          timer_d = INACTIVE_LD;
          state_d = ST_CS_INACTIVE;
        end
      end

      ST_CS_INACTIVE: begin
        timer_d = timer_q - TMR_ONE;
        if (timer_q == TMR_ONE) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset; reset aborts any burst at once.
  always_ff @(posedge i_Clk) begin
    // NOTE: registers are written with <= so every flop samples the values
    // from before this edge, independent of statement order.
    if (i_Rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      cs_n_q      <= 1'b1;
      hold_full_q <= 1'b0;
      hold_byte_q <= '0;
      count_q     <= '0;
      tx_sent_q   <= '0;
      rx_cnt_q    <= '0;
      m_tx_dv_q   <= 1'b0;
      m_tx_byte_q <= '0;
      rx_dv_q     <= 1'b0;
      rx_byte_q   <= '0;
      rx_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cs_n_q      <= cs_n_d;
      hold_full_q <= hold_full_d;
      hold_byte_q <= hold_byte_d;
      count_q     <= count_d;
      tx_sent_q   <= tx_sent_d;
      rx_cnt_q    <= rx_cnt_d;
      m_tx_dv_q   <= m_tx_dv_d;
      m_tx_byte_q <= m_tx_byte_d;
      rx_dv_q     <= rx_dv_d;
      rx_byte_q   <= rx_byte_d;
      rx_count_q  <= rx_count_d;
    end
  end

  assign o_TX_Ready  = tx_ready && !i_Rst;
  assign o_RX_Count  = rx_count_q;
  assign o_RX_DV     = rx_dv_q;
  assign o_RX_Byte   = rx_byte_q;
  assign o_M_TX_Byte = m_tx_byte_q;
  assign o_M_TX_DV   = m_tx_dv_q;
  assign o_SPI_CS_n  = cs_n_q;

endmodule
